// File: rtl/camera_cfg_pkg.sv
// Shared definitions for the OV7670 boot-time configuration sequencer.
// Holds the SCCB write ID, the ROM marker words, the frame width, the
// sequencer state enum and a helper that packs one ROM entry into a
// 27-bit SCCB write frame.
package camera_cfg_pkg;

    localparam logic [7:0]  SCCB_WRITE_ID = 8'h42;
    localparam logic [15:0] CFG_DELAY     = 16'hFFF0;
    localparam logic [15:0] CFG_END       = 16'hFFFF;
    localparam int          FRAME_BITS    = 27;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_START = 3'd2,
        ST_BIT   = 3'd3,
        ST_STOP  = 3'd4,
        ST_GAP   = 3'd5,
        ST_DELAY = 3'd6,
        ST_DONE  = 3'd7
    } cfg_state_t;

    // Each don't-care (ACK) slot is a 1 so the shifter releases SIOD there.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [15:0] entry);
        return {SCCB_WRITE_ID, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
    endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// Combinational register ROM for the OV7670 configuration sequencer.
// Ports:
//   addr [5:0]  - entry index
//   data [15:0] - {reg_addr, value}, or the delay / end marker
// ROM_SEL picks the image: 0 = RGB565/QVGA production table, 1..3 = small
// bring-up images (single write, single delay, 64 writes with no end marker).
module ov7670_reg_rom
    import camera_cfg_pkg::*;
#(
    parameter int ROM_SEL = 0
) (
    input  logic [5:0]  addr,
    output logic [15:0] data
);

    // Table lookup; anything not listed reads as the end marker.
    always_comb begin
        data = CFG_END;
        case (ROM_SEL)
            0: begin
                case (addr)
                    6'd0:    data = 16'h1280;  // COM7 soft reset
                    6'd1:    data = CFG_DELAY; // let the sensor settle
                    6'd2:    data = 16'h1214;  // COM7 QVGA, RGB
                    6'd3:    data = 16'h40D0;  // COM15 RGB565, full range
                    6'd4:    data = 16'h8C00;  // RGB444 off
                    6'd5:    data = 16'h0400;  // COM1
                    6'd6:    data = 16'h1100;  // CLKRC
                    6'd7:    data = 16'h0C04;  // COM3 scaling enable
                    6'd8:    data = 16'h3E19;  // COM14 PCLK divide
                    6'd9:    data = 16'h703A;
                    6'd10:   data = 16'h7135;
                    6'd11:   data = 16'h7211;
                    6'd12:   data = 16'h73F1;
                    6'd13:   data = 16'hA202;
                    6'd14:   data = 16'h3A04;  // TSLB
                    6'd15:   data = 16'h3DC8;  // COM13
                    6'd16:   data = 16'h1714;  // HSTART
                    6'd17:   data = 16'h1802;  // HSTOP
                    6'd18:   data = 16'h3280;  // HREF
                    6'd19:   data = 16'h1903;  // VSTART
                    6'd20:   data = 16'h1A7B;  // VSTOP
                    6'd21:   data = 16'h030A;  // VREF
                    6'd22:   data = 16'h13E7;  // COM8 AGC/AEC/AWB
                    6'd23:   data = 16'h6F9F;
                    6'd24:   data = 16'hB084;
                    default: data = CFG_END;
                endcase
            end
            1: data = (addr == 6'd0) ? 16'h1280 : CFG_END;
            2: data = (addr == 6'd0) ? CFG_DELAY : CFG_END;
            3: data = {2'b01, addr, 2'b10, addr};
            default: data = CFG_END;
        endcase
    end

endmodule

// File: rtl/ov7670_sccb_config.sv
// OV7670 boot-time SCCB configuration sequencer.
// After `start` it walks the register ROM and issues one 3-phase SCCB write
// per entry, honours delay / end markers, then reports `done`.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   start       - one-cycle request to run the ROM sequence (IDLE/DONE only)
//   sioc        - SCCB clock, push-pull
//   siod_oe     - 1 pulls SIOD low, 0 releases it
//   busy, done  - sequence in progress / completed (never both)
//   reg_index   - ROM index currently being processed
module ov7670_sccb_config
    import camera_cfg_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int SCCB_HZ      = 100_000,
    parameter int DELAY_CYCLES = CLK_HZ / 100,
    parameter int ROM_DEPTH    = 64,
    parameter int ROM_SEL      = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       sioc,
    output logic       siod_oe,
    output logic       busy,
    output logic       done,
    output logic [5:0] reg_index
);

    localparam int QDIV = CLK_HZ / (4 * SCCB_HZ);
    localparam int QW   = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam int DW   = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    // Finishing this index means the next one would be the last ROM slot.
    localparam logic [5:0] LAST_IDX = 6'(ROM_DEPTH - 2);

    cfg_state_t            state_r, state_s;
    logic [QW-1:0]         qcnt_r, qcnt_s;
    logic [1:0]            phase_r, phase_s;
    logic [4:0]            bit_r, bit_s;
    logic [FRAME_BITS-1:0] shift_r, shift_s;
    logic [DW-1:0]         dly_r, dly_s;
    logic [5:0]            idx_r, idx_s;
    logic                  sioc_r, sioc_s;
    logic                  oe_r, oe_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
    logic                  tick_s;
    logic                  advance_s;
    logic [15:0]           rom_data_s;

    ov7670_reg_rom #(
        .ROM_SEL (ROM_SEL)
    ) u_rom (
        .addr (idx_r),
        .data (rom_data_s)
    );

    assign tick_s = (qcnt_r == QW'(QDIV - 1));

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            qcnt_r  <= {QW{1'b0}};
            phase_r <= 2'd0;
            bit_r   <= 5'd0;
            shift_r <= {FRAME_BITS{1'b1}};
            dly_r   <= {DW{1'b0}};
            idx_r   <= 6'd0;
            sioc_r  <= 1'b1;
            oe_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            qcnt_r  <= qcnt_s;
            phase_r <= phase_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            dly_r   <= dly_s;
            idx_r   <= idx_s;
            sioc_r  <= sioc_s;
            oe_r    <= oe_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state logic; bus levels are decoded from the next state so they
    // register alongside it.
    always_comb begin
        state_s   = state_r;
        qcnt_s    = qcnt_r;
        phase_s   = phase_r;
        bit_s     = bit_r;
        shift_s   = shift_r;
        dly_s     = dly_r;
        idx_s     = idx_r;
        busy_s    = busy_r;
        done_s    = done_r;
        advance_s = 1'b0;
        sioc_s    = 1'b1;
        oe_s      = 1'b0;

        // Quarter counter only runs while a frame is on the bus, so entry
        // to START always begins a full quarter.
        if (state_r == ST_START || state_r == ST_BIT ||
            state_r == ST_STOP  || state_r == ST_GAP) begin
            if (tick_s) begin
                qcnt_s = {QW{1'b0}};
            end else begin
                qcnt_s = qcnt_r + QW'(1);
            end
        end else begin
            qcnt_s = {QW{1'b0}};
        end

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s = ST_FETCH;
                    idx_s   = 6'd0;
                    busy_s  = 1'b1;
                    done_s  = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_FETCH: begin
                if (rom_data_s == CFG_END) begin
                    state_s = ST_DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else if (rom_data_s == CFG_DELAY) begin
                    state_s = ST_DELAY;
                    dly_s   = {DW{1'b0}};
                end else begin
                    state_s = ST_START;
                    phase_s = 2'd0;
                    shift_s = make_frame(rom_data_s);
                end
            end
            ST_START: begin
                if (tick_s) begin
                    if (phase_r == 2'd1) begin
                        state_s = ST_BIT;
                        phase_s = 2'd0;
                        bit_s   = 5'd0;
                    end else begin
                        phase_s = phase_r + 2'd1;
                    end
                end else begin
                    phase_s = phase_r;
                end
            end
            ST_BIT: begin
                if (tick_s) begin
                    if (phase_r == 2'd3) begin
                        phase_s = 2'd0;
                        shift_s = {shift_r[FRAME_BITS-2:0], 1'b1};
                        if (bit_r == 5'(FRAME_BITS - 1)) begin
                            state_s = ST_STOP;
                        end else begin
                            bit_s = bit_r + 5'd1;
                        end
                    end else begin
                        phase_s = phase_r + 2'd1;
                    end
                end else begin
                    phase_s = phase_r;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    if (phase_r == 2'd2) begin
                        state_s = ST_GAP;
                        phase_s = 2'd0;
                    end else begin
                        phase_s = phase_r + 2'd1;
                    end
                end else begin
                    phase_s = phase_r;
                end
            end
            ST_GAP: begin
                if (tick_s && phase_r == 2'd3) begin
                    advance_s = 1'b1;
                end else if (tick_s) begin
                    phase_s = phase_r + 2'd1;
                end else begin
                    phase_s = phase_r;
                end
            end
            ST_DELAY: begin
                if (dly_r == DW'(DELAY_CYCLES - 1)) begin
                    advance_s = 1'b1;
                end else begin
                    dly_s = dly_r + DW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b0;
            end
        endcase

        // Move to the next entry; a ROM without an end marker stops short
        // of its final slot.
        if (advance_s) begin
            idx_s   = idx_r + 6'd1;
            phase_s = 2'd0;
            if (idx_r == LAST_IDX) begin
                state_s = ST_DONE;
                busy_s  = 1'b0;
                done_s  = 1'b1;
            end else begin
                state_s = ST_FETCH;
            end
        end else begin
            idx_s = idx_s;
        end

        case (state_s)
            ST_START: begin
                sioc_s = (phase_s == 2'd0);
                oe_s   = 1'b1;
            end
            ST_BIT: begin
                sioc_s = phase_s[1];
                oe_s   = ~shift_s[FRAME_BITS-1];
            end
            ST_STOP: begin
                sioc_s = (phase_s != 2'd0);
                oe_s   = (phase_s != 2'd2);
            end
            default: begin
                sioc_s = 1'b1;
                oe_s   = 1'b0;
            end
        endcase
    end

    assign sioc      = sioc_r;
    assign siod_oe   = oe_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign reg_index = idx_r;

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Bench for ov7670_sccb_config. Four instances share the clock, one per ROM
// image (production, single write, single delay, no end marker). A trace
// model expands each ROM into its expected per-cycle bus waveform and every
// cycle is compared; literal checks pin latency, frame bits and counts.
module tb_ov7670_sccb_config;

    localparam int QDIV = 2;   // 800 Hz / (4 * 100 Hz)
    localparam int DLY  = 50;
    localparam int TMAX = 16384;

    logic       clk;
    logic [3:0] rst;
    logic [3:0] st;
    logic       sioc_w [4];
    logic       oe_w   [4];
    logic       busy_w [4];
    logic       done_w [4];
    logic [5:0] ridx   [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ov7670_sccb_config #(
            .CLK_HZ       (800),
            .SCCB_HZ      (100),
            .DELAY_CYCLES (DLY),
            .ROM_DEPTH    (64),
            .ROM_SEL      (g)
        ) u_dut (
            .clk       (clk),
            .reset     (rst[g]),
            .start     (st[g]),
            .sioc      (sioc_w[g]),
            .siod_oe   (oe_w[g]),
            .busy      (busy_w[g]),
            .done      (done_w[g]),
            .reg_index (ridx[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int nprint = 0;
    bit armed = 1'b0;

    logic [15:0] prod [26] = '{16'h1280, 16'hFFF0, 16'h1214, 16'h40D0, 16'h8C00,
                               16'h0400, 16'h1100, 16'h0C04, 16'h3E19, 16'h703A,
                               16'h7135, 16'h7211, 16'h73F1, 16'hA202, 16'h3A04,
                               16'h3DC8, 16'h1714, 16'h1802, 16'h3280, 16'h1903,
                               16'h1A7B, 16'h030A, 16'h13E7, 16'h6F9F, 16'hB084,
                               16'hFFFF};

    // Expected per-cycle tuple {sioc, siod_oe, busy, done, reg_index}.
    logic [9:0] tr [4][TMAX];
    int         len [4];
    int         pos [4];
    logic [9:0] cur [4];
    logic [9:0] rest [4];
    int         bn;

    function automatic logic [15:0] brom(input int sel, input int a);
        logic [5:0] a6;
        a6 = a[5:0];
        if (sel == 0) return (a < 26) ? prod[a] : 16'hFFFF;
        if (sel == 1) return (a == 0) ? 16'h1280 : 16'hFFFF;
        if (sel == 2) return (a == 0) ? 16'hFFF0 : 16'hFFFF;
        return {2'b01, a6, 2'b10, a6};
    endfunction

    task automatic push_q(input int g, input logic s, input logic o, input logic [5:0] ix);
        for (int c = 0; c < QDIV; c++) begin
            tr[g][bn] = {s, o, 1'b1, 1'b0, ix};
            bn++;
        end
    endtask

    // Expand the ROM walk into the full expected waveform from index 0.
    task automatic build(input int g);
        logic [15:0] e;
        logic [26:0] fr;
        logic [5:0]  ix;
        logic        v;
        bit          fin;
        bn  = 0;
        fin = 1'b0;
        for (int i = 0; i < 63; i++) begin
            if (!fin) begin
                e  = brom(g, i);
                ix = 6'(i);
                tr[g][bn] = {4'b1010, ix};
                bn++;
                if (e == 16'hFFFF) begin
                    rest[g] = {4'b1001, ix};
                    fin = 1'b1;
                end else begin
                    if (e == 16'hFFF0) begin
                        for (int c = 0; c < DLY; c++) begin
                            tr[g][bn] = {4'b1010, ix};
                            bn++;
                        end
                    end else begin
                        fr = {8'h42, 1'b1, e[15:8], 1'b1, e[7:0], 1'b1};
                        push_q(g, 1'b1, 1'b1, ix);
                        push_q(g, 1'b0, 1'b1, ix);
                        for (int b = 26; b >= 0; b--) begin
                            v = ~fr[b];
                            push_q(g, 1'b0, v, ix);
                            push_q(g, 1'b0, v, ix);
                            push_q(g, 1'b1, v, ix);
                            push_q(g, 1'b1, v, ix);
                        end
                        push_q(g, 1'b0, 1'b1, ix);
                        push_q(g, 1'b1, 1'b1, ix);
                        push_q(g, 1'b1, 1'b0, ix);
                        for (int k = 0; k < 4; k++) push_q(g, 1'b1, 1'b0, ix);
                    end
                    if (i == 62) begin
                        rest[g] = {4'b1001, 6'd63};
                        fin = 1'b1;
                    end
                end
            end
        end
        len[g] = bn;
        pos[g] = 0;
    endtask

    // Model: advance the expected trace at every clock edge.
    initial begin
        forever begin
            @(posedge clk);
            for (int g = 0; g < 4; g++) begin
                if (rst[g]) begin
                    len[g]  = 0;
                    pos[g]  = 0;
                    rest[g] = {4'b1000, 6'd0};
                    cur[g]  = {4'b1000, 6'd0};
                end else begin
                    if (st[g] && !cur[g][7]) build(g);
                    if (pos[g] < len[g]) begin
                        cur[g] = tr[g][pos[g]];
                        pos[g]++;
                    end else begin
                        cur[g] = rest[g];
                    end
                end
            end
        end
    end

    // Compare every DUT against the model mid-cycle.
    initial begin
        logic [9:0] act;
        forever begin
            @(negedge clk);
            if (armed) begin
                for (int g = 0; g < 4; g++) begin
                    act = {sioc_w[g], oe_w[g], busy_w[g], done_w[g], ridx[g]};
                    total++;
                    if (act !== cur[g] || (busy_w[g] && done_w[g])) begin
                        bad++;
                        if (nprint < 20)
                            $display("FAIL trace dut%0d t=%0t: got %b required %b", g, $time, act, cur[g]);
                        nprint++;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    int          r_cyc, r_rises, r_starts, r_stops, r_falls;
    logic [31:0] r_bits;

    // Pulse start, then watch the bus until done (bounded), optionally
    // throwing in stray start pulses while busy.
    task automatic run_seq(input int g, input int budget, input bit noise);
        int   cnt;
        logic ps, po;
        @(negedge clk);
        st[g] = 1'b1;
        @(negedge clk);
        st[g] = 1'b0;
        cnt = 1;
        r_rises = 0; r_starts = 0; r_stops = 0; r_falls = 0; r_bits = 32'd0;
        ps = sioc_w[g];
        po = oe_w[g];
        while (done_w[g] !== 1'b1 && cnt < budget) begin
            @(negedge clk);
            cnt++;
            st[g] = noise && busy_w[g] && ($urandom_range(0, 63) == 0);
            if (!ps && sioc_w[g]) begin
                r_rises++;
                r_bits = {r_bits[30:0], ~oe_w[g]};
            end
            if (ps && !sioc_w[g]) r_falls++;
            if (ps && sioc_w[g] && !po && oe_w[g]) r_starts++;
            if (ps && sioc_w[g] && po && !oe_w[g]) r_stops++;
            ps = sioc_w[g];
            po = oe_w[g];
        end
        st[g] = 1'b0;
        chk("done_reached", int'(done_w[g] === 1'b1), 1);
        r_cyc = cnt - 1;
    endtask

    task automatic chk_frame1(input string tag);
        chk({tag, "_lat"},    r_cyc, 236);
        chk({tag, "_rises"},  r_rises, 28);
        chk({tag, "_id"},     int'(r_bits[27:20]), 8'h42);
        chk({tag, "_addr"},   int'(r_bits[18:11]), 8'h12);
        chk({tag, "_data"},   int'(r_bits[9:2]), 8'h80);
        chk({tag, "_acks"},   int'({r_bits[19], r_bits[10], r_bits[1]}), 7);
        chk({tag, "_starts"}, r_starts, 1);
        chk({tag, "_stops"},  r_stops, 1);
    endtask

    initial begin
        int off;
        rst = 4'hF;
        st  = 4'h0;
        repeat (3) @(negedge clk);
        armed = 1'b1;
        rst = 4'h0;

        // Reset, no start: idle bus for 1000 clocks.
        repeat (1000) @(negedge clk);
        for (int g = 0; g < 4; g++)
            chk("idle_outputs", int'({sioc_w[g], oe_w[g], busy_w[g], done_w[g], ridx[g]}), 10'b1000_000000);

        // Single write, with stray starts while busy, then a rerun from DONE.
        run_seq(1, 2000, 1'b1);
        chk_frame1("w1");
        chk("w1_done_idx", int'(ridx[1]), 1);
        repeat ($urandom_range(1, 20)) @(negedge clk);
        run_seq(1, 2000, 1'b0);
        chk_frame1("w1_rerun");

        // Delay marker only: no SIOC activity.
        run_seq(2, 500, 1'b0);
        chk("dly_lat", r_cyc, 52);
        chk("dly_falls", r_falls, 0);

        // Reset during bit 10 of the first write of the production ROM.
        @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        off = $urandom_range(86, 93);
        repeat (off - 1) @(negedge clk);
        chk("pre_reset_busy", int'(busy_w[0]), 1);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("rst_sioc", int'(sioc_w[0]), 1);
        chk("rst_oe", int'(oe_w[0]), 0);
        chk("rst_busy", int'(busy_w[0]), 0);
        repeat ($urandom_range(1, 10)) @(negedge clk);

        // Full production ROM replayed from index 0.
        run_seq(0, 8000, 1'b1);
        chk("prod_lat", r_cyc, 24 * 235 + 52);
        chk("prod_writes", r_starts, 24);
        chk("prod_end_idx", int'(ridx[0]), 25);

        // No end marker: stops after index 62, 63 writes.
        run_seq(3, 16000, 1'b1);
        chk("full_lat", r_cyc, 63 * 235);
        chk("full_writes", r_starts, 63);
        chk("full_stops", r_stops, 63);
        chk("full_idx", int'(ridx[3]), 63);
        repeat (20) @(negedge clk);
        chk("full_idle", int'({sioc_w[3], oe_w[3], busy_w[3], done_w[3]}), 4'b1001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
